btb_update_queue: RTL
=====================

// Module: btb_update_queue
// PURPOSE
//  Buffers BTB update requests from the Ctrl Queue: resolved control instructions, in program order,
//  up to two per cycle. Drains them to the BTB write port at one per cycle.
//  Sits directly upstream of the BTB. It drives updateEn/updatePC/updateTargetAddr/updateBrType.
//  Decouples the 2-wide commit burst from the single BTB write port.
// PARAMETERS
//  DEPTH        16  queue entries (power of 2, >= 4)
//  DEPTH_LOG     4  log2(DEPTH)
//  SIZE_PC      32  PC / target width
//  BRANCH_TYPE   2  control-type field width
// PORTS
//  clk                 in   1            clock
//  reset               in   1            synchronous, active-high reset
//  enq0_i              in   1            lane0 update valid (older of the two)
//  enqPC0_i            in   SIZE_PC      lane0 branch PC
//  enqTarget0_i        in   SIZE_PC      lane0 resolved target
//  enqBrType0_i        in   BRANCH_TYPE  lane0 control type
//  enq1_i              in   1            lane1 update valid (younger)
//  enqPC1_i            in   SIZE_PC      lane1 branch PC
//  enqTarget1_i        in   SIZE_PC      lane1 resolved target
//  enqBrType1_i        in   BRANCH_TYPE  lane1 control type
//  stall_i             in   1            hold: no dequeue this cycle
//  updateEn_o          out  1            BTB write enable (registered)
//  updatePC_o          out  SIZE_PC      BTB update PC (registered)
//  updateTargetAddr_o  out  SIZE_PC      BTB update target (registered)
//  updateBrType_o      out  BRANCH_TYPE  BTB update type (registered)
//  full_o              out  1            fewer than 2 free entries; producer must not enqueue
//  count_o             out  DEPTH_LOG+1  occupied entries
//  overflow_o          out  1            sticky: an enqueue was dropped for lack of space
// BEHAVIOUR
//  - Reset: headPtr=tailPtr=0, count=0. All outputs 0 (updateEn_o, updatePC_o, updateTargetAddr_o,
//    updateBrType_o, full_o, count_o, overflow_o). Storage contents are don't-care.
//  - Circular buffer. headPtr and tailPtr are DEPTH_LOG bits and wrap modulo DEPTH.
//  - count_o is DEPTH_LOG+1 bits and ranges 0..DEPTH.
//  - Enqueue: valid lanes are written in lane order at tail, tail+1. Lane1 alone is written at tail.
//    tailPtr advances by the number of lanes written.
//  - Space check uses count at cycle start, plus one free slot from a same-cycle dequeue.
//    Lane0 has priority. A lane with no slot is dropped and sets overflow_o, which stays set until reset.
//  - Dequeue: when count!=0 and !stall_i, the head entry is loaded into the output regs at the edge,
//    updateEn_o=1 for the following cycle, and headPtr increments.
//    Otherwise updateEn_o=0 and the data outputs hold their previous values.
//  - Latency: an entry enqueued at edge N into an empty queue appears with updateEn_o=1 after edge N+1.
//    There is no same-cycle bypass.
//  - Throughput: at most 1 dequeue per cycle. Each entry produces exactly one updateEn_o pulse,
//    in enqueue order.
//  - Simultaneous enq+deq: legal, including at count=DEPTH. count_next = count + writes - deq.
//  - full_o = (count_o > DEPTH-2). It is a combinational decode of the count register.
//  - stall_i only blocks dequeue. Enqueue proceeds normally during stall.
//  - Reset mid-operation discards all pending entries. No update is issued in the cycle after reset.
//  - No flush input: entries are committed state and survive pipeline recovery.
// CONFIGURATION
//  BTB_UPD_FILTER_EN defined:
//   - A valid lane whose {PC,target,type} equals the last-written entry is not written
//     and does not consume space.
//   - The last-written entry is held in a 1-entry register, valid-cleared on reset, compared even if
//     that entry has already been dequeued.
//   - Lane1 is also compared against lane0 of the same cycle when lane0 is written.
//   - A filtered lane does not set overflow_o.
//  BTB_UPD_FILTER_EN undefined:
//   - Every valid lane is written. No compare logic and no last-entry register.
// TESTING
//  1 Reset, then enq0 PC=0x1000 tgt=0x2000 type=1 -> updateEn_o pulses 2 cycles later with those values;
//    count_o returns to 0.
//  2 enq0+enq1 (PC 0x10, 0x18) with stall_i=1 for 3 cycles -> count_o=2, no updateEn_o;
//    on release, PC 0x10 then 0x18 on consecutive cycles.
//  3 Fill to 16 with stall_i=1 -> full_o=1 at count 15. One more lane dropped, overflow_o=1,
//    count_o=16. Unstall: 16 ordered pulses, overflow_o stays 1.
//  4 Pointer wrap: 40 single enqueues at one per cycle while draining
//    -> all 40 PCs emitted in order, count_o<=2 throughout.
//  5 Reset asserted with 5 pending entries -> next cycle all outputs 0; no stale updateEn_o afterwards.
//  6 FILTER_EN: enqueue identical PC/tgt/type twice -> exactly one updateEn_o;
//    differing target -> two pulses. Without macro: two pulses in both cases.

Source files
------------

// File: rtl/btb_update_queue.sv
// Two-lane-in, one-lane-out circular queue of BTB updates between the Ctrl Queue and the BTB.
// Optional duplicate-update filter enabled by defining BTB_UPD_FILTER_EN.
module btb_update_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned DEPTH_LOG   = 4,
  parameter int unsigned SIZE_PC     = 32,
  parameter int unsigned BRANCH_TYPE = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq0_i,
  input  logic [SIZE_PC-1:0]     enqPC0_i,
  input  logic [SIZE_PC-1:0]     enqTarget0_i,
  input  logic [BRANCH_TYPE-1:0] enqBrType0_i,
  input  logic                   enq1_i,
  input  logic [SIZE_PC-1:0]     enqPC1_i,
  input  logic [SIZE_PC-1:0]     enqTarget1_i,
  input  logic [BRANCH_TYPE-1:0] enqBrType1_i,
  input  logic                   stall_i,
  output logic                   updateEn_o,
  output logic [SIZE_PC-1:0]     updatePC_o,
  output logic [SIZE_PC-1:0]     updateTargetAddr_o,
  output logic [BRANCH_TYPE-1:0] updateBrType_o,
  output logic                   full_o,
  output logic [DEPTH_LOG:0]     count_o,
  output logic                   overflow_o
);

  localparam int unsigned EntryW = 2 * SIZE_PC + BRANCH_TYPE;
  localparam logic [DEPTH_LOG+1:0] DepthW  = (DEPTH_LOG + 2)'(DEPTH);
  localparam logic [DEPTH_LOG:0]   FullThr = (DEPTH_LOG + 1)'(DEPTH - 2);

  logic [EntryW-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG-1:0] head_q, tail_q;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 overflow_q;
  logic                 upd_en_q;
  logic [EntryW-1:0]    upd_q;

  logic [EntryW-1:0]    lane0, lane1;
  logic                 deq, want0, want1, wr0, wr1, filt0, filt1;
  logic [DEPTH_LOG+1:0] free_slots;
  logic [DEPTH_LOG-1:0] idx1;

  assign lane0 = {enqPC0_i, enqTarget0_i, enqBrType0_i};
  assign lane1 = {enqPC1_i, enqTarget1_i, enqBrType1_i};

  assign deq = (count_q != '0) && !stall_i;

  // Free space counts the slot vacated by a dequeue in the same cycle.
  assign free_slots = DepthW - {1'b0, count_q} + {{(DEPTH_LOG + 1){1'b0}}, deq};

  assign want0 = enq0_i && !filt0;
  assign want1 = enq1_i && !filt1;
  assign wr0   = want0 && (free_slots != '0);
  assign wr1   = want1 && (free_slots > (DEPTH_LOG + 2)'(wr0));
  assign idx1  = tail_q + DEPTH_LOG'(wr0);

`ifdef BTB_UPD_FILTER_EN
  logic              last_vld_q;
  logic [EntryW-1:0] last_q;

  assign filt0 = last_vld_q && (lane0 == last_q);
  assign filt1 = (last_vld_q && (lane1 == last_q)) || (wr0 && (lane1 == lane0));

  always_ff @(posedge clk) begin
    if (reset) begin
      last_vld_q <= 1'b0;
      last_q     <= '0;
    end else if (wr1) begin
      last_vld_q <= 1'b1;
      last_q     <= lane1;
    end else if (wr0) begin
      last_vld_q <= 1'b1;
      last_q     <= lane0;
    end
  end
`else
  assign filt0 = 1'b0;
  assign filt1 = 1'b0;
`endif

  always_comb begin
    count_d = count_q + (DEPTH_LOG + 1)'(wr0) + (DEPTH_LOG + 1)'(wr1) - (DEPTH_LOG + 1)'(deq);
  end

  // Storage is not reset; contents are only observed through the occupancy count.
  always_ff @(posedge clk) begin
    if (wr0) mem_q[tail_q] <= lane0;
    if (wr1) mem_q[idx1]   <= lane1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      upd_en_q   <= 1'b0;
      upd_q      <= '0;
    end else begin
      tail_q  <= tail_q + DEPTH_LOG'(wr0) + DEPTH_LOG'(wr1);
      count_q <= count_d;
      if ((want0 && !wr0) || (want1 && !wr1)) overflow_q <= 1'b1;
      upd_en_q <= deq;
      if (deq) begin
        upd_q  <= mem_q[head_q];
        head_q <= head_q + 1'b1;
      end
    end
  end

  assign updateEn_o = upd_en_q;
  assign {updatePC_o, updateTargetAddr_o, updateBrType_o} = upd_q;
  assign full_o     = count_q > FullThr;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
